// File: rtl/tdm_demux4.sv
// ----------------------------------------------------------------------------
// tdm_demux4 : reassembles 4-beat TDM frames (sof marks slot 0) into one word
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tdm_demux4 #(
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   din,
  input  logic           din_valid,
  input  logic           sof,
  output logic [4*W-1:0] o,
  output logic           o_valid,
  output logic [1:0]     s,
  output logic           err
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     s_q, s_d;
  logic [4*W-1:0] asm_q, asm_d;
  logic [4*W-1:0] o_q, o_d;
  logic           o_valid_q, o_valid_d;
  logic           err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      s_q       <= 2'd0;
      asm_q     <= '0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      asm_q     <= asm_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    asm_d     = asm_q;
    o_d       = o_q;
    o_valid_d = 1'b0;
    err_d     = 1'b0;
    if (din_valid) begin
      case (state_q)
        IDLE: begin
          // Beats without sof are stray data outside any frame: drop silently.
          if (sof) begin
            asm_d[W-1:0] = din;
            s_d          = 2'd1;
            state_d      = COLLECT;
          end
        end
        COLLECT: begin
          if (sof) begin
            err_d        = 1'b1;
            asm_d[W-1:0] = din;
            s_d          = 2'd1;
          end else begin
            for (int k = 1; k < 4; k++) begin
              if (s_q == 2'(k)) asm_d[k*W +: W] = din;
            end
            if (s_q == 2'd3) begin
              o_d       = {din, asm_q[3*W-1:0]};
              o_valid_d = 1'b1;
              s_d       = 2'd0;
              state_d   = IDLE;
            end else begin
              s_d = s_q + 2'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign o       = o_q;
  assign o_valid = o_valid_q;
  assign s       = s_q;
  assign err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux4.sv
// ----------------------------------------------------------------------------
// tb_tdm_demux4 : directed self-checking bench for tdm_demux4 with W=1
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_tdm_demux4;

  logic       clk;
  logic       rst;
  logic [0:0] din;
  logic       din_valid;
  logic       sof;
  logic [3:0] o;
  logic       o_valid;
  logic [1:0] s;
  logic       err;

  int checks   = 0;
  int failures = 0;

  tdm_demux4 #(.W(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .sof       (sof),
    .o         (o),
    .o_valid   (o_valid),
    .s         (s),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle; outputs are sampled 1ns after the edge.
  task automatic step(input logic v, input logic sf, input logic d);
    din_valid = v;
    sof       = sf;
    din       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic v, input logic sf, input logic d,
                      input logic [1:0] es, input logic eov, input logic eerr);
    step(v, sf, d);
    chk({tag, "_s"},   32'(s),       32'(es));
    chk({tag, "_ov"},  32'(o_valid), 32'(eov));
    chk({tag, "_err"}, 32'(err),     32'(eerr));
  endtask

  initial begin
    rst = 1'b1; din_valid = 1'b0; sof = 1'b0; din = 1'b0;
    #1;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("rst_o",   32'(o),       32'h0);
    chk("rst_ov",  32'(o_valid), 32'h0);
    chk("rst_err", 32'(err),     32'h0);
    chk("rst_s",   32'(s),       32'h0);
    rst = 1'b0;
    beat("idle", 0, 0, 0, 2'd0, 0, 0);

    // Single frames: lane position follows slot index
    beat("f1b0", 1, 1, 1, 2'd1, 0, 0);
    beat("f1b1", 1, 0, 0, 2'd2, 0, 0);
    beat("f1b2", 1, 0, 0, 2'd3, 0, 0);
    chk("f1_o_pre", 32'(o), 32'h0);
    beat("f1b3", 1, 0, 0, 2'd0, 1, 0);
    chk("f1_o", 32'(o), 32'h1);
    beat("f1gap", 0, 0, 0, 2'd0, 0, 0);
    chk("f1_hold", 32'(o), 32'h1);

    beat("f2b0", 1, 1, 0, 2'd1, 0, 0);
    beat("f2b1", 1, 0, 0, 2'd2, 0, 0);
    beat("f2b2", 1, 0, 1, 2'd3, 0, 0);
    beat("f2b3", 1, 0, 0, 2'd0, 1, 0);
    chk("f2_o", 32'(o), 32'h4);

    beat("f3b0", 1, 1, 0, 2'd1, 0, 0);
    beat("f3b1", 1, 0, 0, 2'd2, 0, 0);
    beat("f3b2", 1, 0, 0, 2'd3, 0, 0);
    beat("f3b3", 1, 0, 1, 2'd0, 1, 0);
    chk("f3_o", 32'(o), 32'h8);
    beat("f3gap", 0, 0, 0, 2'd0, 0, 0);

    // Back-to-back with a gap inside frame 1: s = 1,2,2,3,0,1,2,3,0
    beat("bb0", 1, 1, 1, 2'd1, 0, 0);
    beat("bb1", 1, 0, 1, 2'd2, 0, 0);
    beat("bbg", 0, 1, 0, 2'd2, 0, 0);
    beat("bb2", 1, 0, 0, 2'd3, 0, 0);
    beat("bb3", 1, 0, 0, 2'd0, 1, 0);
    chk("bb_o1", 32'(o), 32'h3);
    beat("bb4", 1, 1, 0, 2'd1, 0, 0);
    chk("bb_o1_hold", 32'(o), 32'h3);
    beat("bb5", 1, 0, 0, 2'd2, 0, 0);
    beat("bb6", 1, 0, 0, 2'd3, 0, 0);
    beat("bb7", 1, 0, 1, 2'd0, 1, 0);
    chk("bb_o2", 32'(o), 32'h8);

    // Short frame: second sof after 3 beats restarts assembly and flags err
    beat("sh0", 1, 1, 1, 2'd1, 0, 0);
    beat("sh1", 1, 0, 1, 2'd2, 0, 0);
    beat("sh2", 1, 0, 1, 2'd3, 0, 0);
    beat("sh3", 1, 1, 1, 2'd1, 0, 1);
    chk("sh_o_a", 32'(o), 32'h8);
    beat("sh4", 1, 0, 0, 2'd2, 0, 0);
    beat("sh5", 1, 0, 1, 2'd3, 0, 0);
    chk("sh_o_b", 32'(o), 32'h8);
    beat("sh6", 1, 0, 0, 2'd0, 1, 0);
    chk("sh_o", 32'(o), 32'h5);

    // Stray beats in IDLE after reset
    rst = 1'b1;
    step(1, 1, 1);
    rst = 1'b0;
    chk("st_rst_o", 32'(o), 32'h0);
    beat("st0", 1, 0, 1, 2'd0, 0, 0);
    beat("st1", 1, 0, 1, 2'd0, 0, 0);
    beat("st2", 1, 0, 1, 2'd0, 0, 0);
    chk("st_o", 32'(o), 32'h0);

    // Reset mid-frame discards partial frame without err
    beat("rm0", 1, 1, 1, 2'd1, 0, 0);
    beat("rm1", 1, 0, 1, 2'd2, 0, 0);
    rst = 1'b1;
    beat("rmr", 1, 1, 1, 2'd0, 0, 0);
    rst = 1'b0;
    beat("rm2", 1, 1, 0, 2'd1, 0, 0);
    beat("rm3", 1, 0, 1, 2'd2, 0, 0);
    beat("rm4", 1, 0, 1, 2'd3, 0, 0);
    chk("rm_o_pre", 32'(o), 32'h0);
    beat("rm5", 1, 0, 0, 2'd0, 1, 0);
    chk("rm_o", 32'(o), 32'h6);
    beat("rm6", 0, 0, 0, 2'd0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receiving end of the 4:1 lane mux path.
- Accepts a time-multiplexed stream of beats, one lane per beat, with lane 0 marked by a start-of-frame flag.
- Reassembles each 4-beat frame into a parallel 4-lane word.
- Output ordering is the inverse of the mux: the beat captured in slot k lands on lane k, matching mux input i[k] selected by s=k.

Parameters:
- W, 1, width of one lane and of one serial beat.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  W  serial beat data.
- din_valid  in  1  din carries a beat this cycle.
- sof  in  1  start of frame; qualified by din_valid; marks the slot-0 beat.
- o  out  4*W  last completed frame; lane k at o[k*W +: W].
- o_valid  out  1  one-cycle pulse: o has just been updated with a new frame.
- s  out  2  slot index the next non-sof beat will fill (0 in IDLE).
- err  out  1  one-cycle pulse: frame-sync error, partial frame discarded.

Behaviour:
- Reset (rst=1 at a clock edge):
  - o=0, o_valid=0, err=0, s=0.
  - Assembly register cleared, state=IDLE.
  - rst overrides every other input in the same cycle.
  - Reset mid-frame discards the partial frame without raising err.
- Beat: din_valid=1 at a clock edge. If din_valid=0, sof is ignored and state, s and assembly hold.
- State IDLE:
  - Beat with sof=1: asm lane 0 <= din, s <= 1, go to COLLECT.
  - Beat with sof=0: dropped, no err, remain in IDLE.
- State COLLECT, beat with sof=0:
  - asm lane s <= din, s <= s+1.
  - If s==3 (4th beat): commit. o <= asm lanes 0..2 plus din on lane 3, o_valid=1 on the next cycle, s <= 0, go to IDLE.
- State COLLECT, beat with sof=1 (short frame):
  - err=1 on the next cycle; the partial frame is discarded and o is unchanged.
  - Restart: asm lane 0 <= din, s <= 1, remain in COLLECT.
- Gaps: din_valid=0 cycles are allowed anywhere inside a frame. There is no timeout.
- Latency and hold:
  - o and o_valid update at the edge that samples the 4th beat, so both are visible the cycle after that beat.
  - o holds its value until the next commit.
  - o_valid and err are single-cycle pulses and are registered.
- Throughput: full rate. A sof beat on the cycle immediately after a 4th beat is accepted, so a continuous stream gives one frame per 4 cycles.
- Simultaneous events: a commit and a new frame cannot occur in the same cycle. err and o_valid are never asserted together.
- Assembly is held separately from o, so o never shows a partial frame.
- s wraps from 3 to 0 only through a commit; no other path reaches 3->0.

Test Plan:
- Reset, then idle cycles: after rst=1 for 2 cycles -> o=0, o_valid=0, err=0, s=0.
- Single frame, W=1: beats (sof,din) = (1,1),(0,0),(0,0),(0,0) on consecutive cycles -> o=4'b0001 and o_valid pulses once, one cycle after the 4th beat. Repeat with din 0,0,1,0 -> o=4'b0100. Repeat with 0,0,0,1 -> o=4'b1000.
- Back-to-back frames with gaps: frames 1,1,0,0 then 0,0,0,1, with a din_valid=0 cycle after beat 2 of frame 1 -> o=4'b0011 then 4'b1000. Exactly two o_valid pulses; s sequence is 1,2,2,3,0,1,2,3,0.
- Short frame: sof, 2 beats, then sof + 3 beats with din=1,0,1,0 -> err pulses once, one cycle after the second sof. o becomes 4'b0101 only after the final beat; o is unchanged before that.
- Stray beats in IDLE: 3 beats with sof=0 after reset -> o=0, no o_valid, no err, s=0.
- Reset mid-frame: assert rst after 2 beats, then send a full frame 0,1,1,0 -> no err. Single o_valid pulse with o=4'b0110.
